serial_work_assembler: RTL
==========================

SERIAL_WORK_ASSEMBLER -- requirements
Module: serial_work_assembler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 32'd13000000 (about 100 ms at 130 MHz): number of consecutive idle clk cycles, with no byte, after which a partial work unit is discarded.
REQ-002 Parameter WORK_BYTES, default 44: bytes per work unit (32 midstate + 12 data); fixed at 44, and no other value is supported.
REQ-003 clk  input  1  single clock; all state is updated on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_byte  input  8  byte from the upstream UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_byte is valid in that cycle.
REQ-007 midstate  output  256  midstate of the last complete work unit; feeds the hasher midstate_buf.
REQ-008 data  output  96  tail data of the last complete work unit; feeds the hasher data_buf.
REQ-009 work_valid  output  1  one-cycle pulse: new midstate/data committed; the nonce counter restarts on it.
REQ-010 busy  output  1  high while a partial work unit is held (state RECV).
REQ-011 timeout_err  output  1  one-cycle pulse: partial work unit discarded on timeout.

Function
REQ-012 The FSM shall have two states: IDLE (byte count 0) and RECV (1..43 bytes held).
REQ-013 IDLE with rx_valid=1: store byte 0, set count=1, clear timer, go to RECV; otherwise remain in IDLE.
REQ-014 RECV with rx_valid=1 and count<43: store the byte at index count, increment count, clear timer.
REQ-015 RECV with rx_valid=1 and count==43: on the same edge, commit the assembled 352 bits to {data, midstate}, pulse work_valid for the following cycle, set count=0, and go to IDLE.
REQ-016 Byte k (0..43) shall land at bits [8k+7:8k] of {data, midstate}: bytes 0..31 form midstate LSB-first, and bytes 32..43 form data LSB-first.
REQ-017 midstate/data shall hold the previous committed values throughout assembly and change only on commit, so the hasher never sees partial work.
REQ-018 RECV with rx_valid=0 shall increment the timer (32-bit, saturating); after TIMEOUT_CYCLES consecutive idle cycles, the next edge discards the partial work: count=0, go to IDLE, timeout_err pulses for one cycle, and midstate/data are unchanged.
REQ-019 If rx_valid=1 arrives in the cycle in which the timeout would fire, the byte wins: it is accepted, the timer clears, and no timeout_err is raised.
REQ-020 Back-to-back rx_valid (every cycle) shall be accepted with no lost bytes; latency from the 44th byte strobe to the work_valid pulse is exactly 1 cycle.
REQ-021 A byte arriving in the cycle in which work_valid is high shall be accepted as byte 0 of the next unit.
REQ-022 busy shall equal (state==RECV), registered.
REQ-023 work_valid and timeout_err shall never be high simultaneously, and each shall be high for at most one cycle per event.
REQ-024 The timer shall not run in IDLE; no timeout_err shall occur from IDLE.

Reset
REQ-025 When reset=1 at an edge: state=IDLE, count=0, timer=0, midstate=0, data=0, work_valid=0, busy=0, timeout_err=0.
REQ-026 Reset overrides rx_valid in the same cycle; the byte is dropped.
REQ-027 Reset in RECV discards the partial unit without a work_valid or timeout_err pulse.

Verification
REQ-028 Send 44 bytes (0x7b,0x43,0x20,0x16,...,0x5e,0x63 then 0x13,0x8d,0x8d,0x1e,...,0x08,0xe1,0xe5), one every 10 cycles -> one work_valid pulse; midstate=635ef71f2ce00832a4b416afc1945ba0d775d72163ab4d6815c08d6e1620437b; data=e5e1081ae9a4374e1e8d8d13.
REQ-029 The same 44 bytes with rx_valid high every cycle -> work_valid exactly 1 cycle after the 44th strobe, with identical values; busy high for exactly 43 cycles.
REQ-030 TIMEOUT_CYCLES=16: send 10 bytes, idle 16 cycles -> timeout_err pulse, busy=0, outputs still zero; then 44 vector bytes -> correct commit.
REQ-031 TIMEOUT_CYCLES=16: 44 vector bytes with 15-cycle gaps, plus one byte landing exactly on the firing cycle -> no timeout_err; correct commit.
REQ-032 20 bytes, then reset for 1 cycle, then 44 vector bytes -> no pulse before the final commit; one work_valid; correct values.
REQ-033 Two consecutive units, the second (all bytes 0xa5) starting in the work_valid cycle -> two pulses 44 cycles apart; midstate={32{8'ha5}}; data={12{8'ha5}}.

Source files
------------

// File: rtl/serial_work_assembler.sv
// serial_work_assembler: collects 44 UART bytes into a midstate/data work unit with idle timeout
module serial_work_assembler #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd13000000,
  parameter int WORK_BYTES = 44
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic         work_valid,
  output logic         busy,
  output logic         timeout_err
);
  localparam int HELD = WORK_BYTES - 1;
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_n;
  logic [5:0] count, count_n;
  logic [31:0] timer, timer_n;
  logic [8*HELD-1:0] buf_q, buf_n;
  logic commit, fire;
  always_comb begin
    state_n = state;
    count_n = count;
    timer_n = timer;
    buf_n = buf_q;
    commit = 1'b0;
    fire = 1'b0;
    if (rx_valid) begin
      timer_n = '0;
      if (state == RECV && count == 6'(HELD)) begin
        commit = 1'b1;
        count_n = '0;
        state_n = IDLE;
      end else begin
        count_n = count + 6'd1;
        state_n = RECV;
        for (int i = 0; i < HELD; i++) buf_n[8*i +: 8] = (count == 6'(i)) ? rx_byte : buf_q[8*i +: 8];
      end
    end else if (state == RECV) begin
      if (timer >= TIMEOUT_CYCLES) begin
        fire = 1'b1;
        count_n = '0;
        timer_n = '0;
        state_n = IDLE;
      end else timer_n = &timer ? timer : timer + 32'd1;
    end
  end
  // The last byte is committed straight from rx_byte, so only 43 bytes are buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      timer <= '0;
      buf_q <= '0;
      midstate <= '0;
      data <= '0;
      work_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      timer <= timer_n;
      buf_q <= buf_n;
      work_valid <= commit;
      timeout_err <= fire;
      if (commit) {data, midstate} <= {rx_byte, buf_q};
    end
  end
  assign busy = (state == RECV);
endmodule
